// File: rtl/sdram32_line_cache.sv
// sdram32_line_cache: direct-mapped, write-back cache of 4x32-bit lines between the
// CPU Wishbone bus and the 4-beat burst SDRAM controller. Hits never touch SDRAM,
// and every SDRAM transaction is a whole-line burst.
// Build option: define SDRAM_CACHE_FLUSH_EN to add flush_i/flush_done_o and the
// dirty-line flush engine.
//
// state    | meaning
// S_IDLE   | ready for a CPU request; the only state with stall low
// S_LOOKUP | tag compare; a hit completes, a miss picks writeback or fill
// S_WB     | 4-beat write burst of the victim (or flushed) line
// S_FILL   | 4-beat read burst into the requested line
// S_FLUSH  | scan of every index for dirty lines (flush builds only)
module sdram32_line_cache #(
  parameter int LINES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_cyc_i,
  input  logic        cpu_stb_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_adr_i,
  input  logic [31:0] cpu_dat_i,
  output logic [31:0] cpu_dat_o,
  output logic        cpu_ack_o,
  output logic        cpu_stall_o,
`ifdef SDRAM_CACHE_FLUSH_EN
  input  logic        flush_i,
  output logic        flush_done_o,
`endif
  output logic        mem_cyc_o,
  output logic        mem_stb_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_adr_o,
  output logic [31:0] mem_dat_o,
  input  logic [31:0] mem_dat_i,
  input  logic        mem_ack_i,
  input  logic        mem_stall_i
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 23 - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB, S_FILL
`ifdef SDRAM_CACHE_FLUSH_EN
    , S_FLUSH
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [26:2]       req_adr_q, req_adr_d;
  logic              req_we_q, req_we_d;
  logic [3:0]        req_sel_q, req_sel_d;
  logic [31:0]       req_dat_q, req_dat_d;
  logic [1:0]        beat_q, beat_d;
  logic [LINES-1:0]  valid_q, valid_d, dirty_q, dirty_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [31:0]       cpu_dat_q, cpu_dat_d;
  logic              mem_cyc_q, mem_cyc_d, mem_we_q, mem_we_d;
  logic [3:0]        mem_sel_q, mem_sel_d;
  logic [31:0]       mem_adr_q, mem_adr_d;

  // Tag and data storage carry no reset; valid gates every use of them.
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES][4];

  logic              data_we, tag_we;
  logic [IDX_W-1:0]  data_idx;
  logic [1:0]        data_off;
  logic [31:0]       data_wdata, hit_word, merged_word;

  logic [1:0]        req_off;
  logic [IDX_W-1:0]  req_idx, cur_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              hit, accept, unused_bits;

  assign req_off  = req_adr_q[3:2];
  assign req_idx  = req_adr_q[4 +: IDX_W];
  assign req_tag  = req_adr_q[4+IDX_W +: TAG_W];
  assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign hit_word = data_mem[req_idx][req_off];
  assign accept   = cpu_cyc_i && cpu_stb_i && !cpu_stall_o;

  // Upper address bits, byte-lane bits and controller stall carry no information here.
  assign unused_bits = ^{cpu_adr_i[31:27], cpu_adr_i[1:0], mem_stall_i};

`ifdef SDRAM_CACHE_FLUSH_EN
  logic              flushing_q, flushing_d, flush_done_q, flush_done_d;
  logic [IDX_W-1:0]  flush_idx_q, flush_idx_d;
  assign cur_idx      = flushing_q ? flush_idx_q : req_idx;
  assign flush_done_o = flush_done_q;
`else
  assign cur_idx      = req_idx;
`endif

  // Byte-lane merge of the pending write into the cached word.
  always_comb begin
    merged_word = hit_word;
    for (int b = 0; b < 4; b++)
      if (req_sel_q[b]) merged_word[8*b +: 8] = req_dat_q[8*b +: 8];
  end

  // Next-state, storage write enables and bus register updates.
  always_comb begin
    state_d    = state_q;
    req_adr_d  = req_adr_q;
    req_we_d   = req_we_q;
    req_sel_d  = req_sel_q;
    req_dat_d  = req_dat_q;
    beat_d     = beat_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    cpu_ack_d  = 1'b0;
    cpu_dat_d  = cpu_dat_q;
    mem_cyc_d  = mem_cyc_q;
    mem_we_d   = mem_we_q;
    mem_sel_d  = mem_sel_q;
    mem_adr_d  = mem_adr_q;
    data_we    = 1'b0;
    data_idx   = req_idx;
    data_off   = req_off;
    data_wdata = merged_word;
    tag_we     = 1'b0;
`ifdef SDRAM_CACHE_FLUSH_EN
    flushing_d   = flushing_q;
    flush_idx_d  = flush_idx_q;
    flush_done_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          req_adr_d = cpu_adr_i[26:2];
          req_we_d  = cpu_we_i;
          req_sel_d = cpu_sel_i;
          req_dat_d = cpu_dat_i;
          state_d   = S_LOOKUP;
        end
`ifdef SDRAM_CACHE_FLUSH_EN
        else if (flush_i) begin
          flushing_d  = 1'b1;
          flush_idx_d = '0;
          state_d     = S_FLUSH;
        end
`endif
      end
      S_LOOKUP: begin
        if (hit) begin
          cpu_ack_d = cpu_cyc_i;
          state_d   = S_IDLE;
          if (req_we_q) begin
            data_we          = 1'b1;
            dirty_d[req_idx] = 1'b1;
            cpu_dat_d        = '0;
          end else begin
            cpu_dat_d = hit_word;
          end
        end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
          state_d = S_WB;
        end else begin
          state_d = S_FILL;
        end
      end
      S_WB: begin
        // A burst starts only from a released bus, which also guarantees the idle
        // cycle between a writeback and the fill that follows it.
        if (!mem_cyc_q) begin
          mem_cyc_d = 1'b1;
          mem_we_d  = 1'b1;
          mem_sel_d = 4'hf;
          mem_adr_d = {5'b0, tag_mem[cur_idx], cur_idx, 4'b0};
          beat_d    = '0;
        end else if (mem_ack_i) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            mem_cyc_d        = 1'b0;
            mem_we_d         = 1'b0;
            mem_sel_d        = '0;
            mem_adr_d        = '0;
            dirty_d[cur_idx] = 1'b0;
`ifdef SDRAM_CACHE_FLUSH_EN
            state_d = flushing_q ? S_FLUSH : S_FILL;
`else
            state_d = S_FILL;
`endif
          end
        end
      end
      S_FILL: begin
        if (!mem_cyc_q) begin
          mem_cyc_d = 1'b1;
          mem_we_d  = 1'b0;
          mem_sel_d = 4'hf;
          mem_adr_d = {5'b0, req_tag, req_idx, 4'b0};
          beat_d    = '0;
        end else if (mem_ack_i) begin
          beat_d     = beat_q + 2'd1;
          data_we    = 1'b1;
          data_off   = beat_q;
          data_wdata = mem_dat_i;
          if (beat_q == 2'd3) begin
            mem_cyc_d        = 1'b0;
            mem_sel_d        = '0;
            mem_adr_d        = '0;
            tag_we           = 1'b1;
            valid_d[req_idx] = 1'b1;
            dirty_d[req_idx] = 1'b0;
            state_d          = S_LOOKUP;
          end
        end
      end
`ifdef SDRAM_CACHE_FLUSH_EN
      S_FLUSH: begin
        // A written-back line comes back here with dirty cleared and then advances.
        if (dirty_q[flush_idx_q]) begin
          state_d = S_WB;
        end else if (flush_idx_q == IDX_W'(LINES - 1)) begin
          flushing_d   = 1'b0;
          flush_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          flush_idx_d = flush_idx_q + 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Control and status registers; reset drops the bus and invalidates every line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      req_adr_q <= '0;
      req_we_q  <= 1'b0;
      req_sel_q <= '0;
      req_dat_q <= '0;
      beat_q    <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
      cpu_ack_q <= 1'b0;
      cpu_dat_q <= '0;
      mem_cyc_q <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_sel_q <= '0;
      mem_adr_q <= '0;
`ifdef SDRAM_CACHE_FLUSH_EN
      flushing_q   <= 1'b0;
      flush_idx_q  <= '0;
      flush_done_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      req_adr_q <= req_adr_d;
      req_we_q  <= req_we_d;
      req_sel_q <= req_sel_d;
      req_dat_q <= req_dat_d;
      beat_q    <= beat_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
      cpu_ack_q <= cpu_ack_d;
      cpu_dat_q <= cpu_dat_d;
      mem_cyc_q <= mem_cyc_d;
      mem_we_q  <= mem_we_d;
      mem_sel_q <= mem_sel_d;
      mem_adr_q <= mem_adr_d;
`ifdef SDRAM_CACHE_FLUSH_EN
      flushing_q   <= flushing_d;
      flush_idx_q  <= flush_idx_d;
      flush_done_q <= flush_done_d;
`endif
    end
  end

  // Line storage writes.
  always_ff @(posedge clk_i) begin
    if (data_we) data_mem[data_idx][data_off] <= data_wdata;
    if (tag_we)  tag_mem[req_idx] <= req_tag;
  end

  assign cpu_dat_o   = cpu_dat_q;
  assign cpu_ack_o   = cpu_ack_q;
  assign cpu_stall_o = (state_q != S_IDLE);
  assign mem_cyc_o   = mem_cyc_q;
  assign mem_stb_o   = mem_cyc_q;
  assign mem_we_o    = mem_we_q;
  assign mem_sel_o   = mem_sel_q;
  assign mem_adr_o   = mem_adr_q;
  assign mem_dat_o   = (mem_cyc_q && mem_we_q) ? data_mem[cur_idx][beat_q] : 32'h0;
endmodule

// File: tb/tb_sdram32_line_cache.sv
// Bench for sdram32_line_cache (LINES=64): a burst controller model with a small
// word memory, plus scoreboards of expected bursts and expected CPU read data.
module tb_sdram32_line_cache;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cpu_cyc_i, cpu_stb_i, cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_adr_i, cpu_dat_i, cpu_dat_o;
  logic        cpu_ack_o, cpu_stall_o;
  logic        mem_cyc_o, mem_stb_o, mem_we_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_adr_o, mem_dat_o, mem_dat_i;
  logic        mem_ack_i, mem_stall_i;
`ifdef SDRAM_CACHE_FLUSH_EN
  logic        flush_i, flush_done_o;
`endif

  localparam logic [31:0] A0 = 32'h0A0A_0A00, A1 = 32'h1122_3344,
                          A2 = 32'h0A0A_0A02, A3 = 32'h0A0A_0A03;

  sdram32_line_cache #(.LINES(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_cyc_i(cpu_cyc_i), .cpu_stb_i(cpu_stb_i), .cpu_we_i(cpu_we_i),
    .cpu_sel_i(cpu_sel_i), .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i),
    .cpu_dat_o(cpu_dat_o), .cpu_ack_o(cpu_ack_o), .cpu_stall_o(cpu_stall_o),
`ifdef SDRAM_CACHE_FLUSH_EN
    .flush_i(flush_i), .flush_done_o(flush_done_o),
`endif
    .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o),
    .mem_sel_o(mem_sel_o), .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o),
    .mem_dat_i(mem_dat_i), .mem_ack_i(mem_ack_i), .mem_stall_i(mem_stall_i)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0, n_chk = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] defw(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  typedef struct packed {
    logic         we;
    logic [31:0]  adr;
    logic [127:0] dat;
  } burst_t;

  burst_t      exp_bursts[$];
  logic [31:0] exp_rd[$];
  logic [31:0] mem_words[1024];
  int          bursts_seen = 0, acks_seen = 0, beat_no = -1;

  task automatic push_burst(input logic we, input logic [31:0] adr, input logic [127:0] dat);
    burst_t b;
    b.we = we; b.adr = adr; b.dat = dat;
    exp_bursts.push_back(b);
  endtask

  // Controller model: 3 wait cycles after stb, then 4 consecutive acks.
  logic [31:0]  m_adr;
  logic         m_we, m_abort, m_hold_ok;
  logic [127:0] m_dat;
  burst_t       m_exp;
  initial begin
    mem_ack_i = 1'b0; mem_dat_i = '0; mem_stall_i = 1'b0;
    for (int i = 0; i < 1024; i++) mem_words[i] = defw(32'(i) << 2);
    mem_words[10'h040] = A0; mem_words[10'h041] = A1;
    mem_words[10'h042] = A2; mem_words[10'h043] = A3;
    forever begin
      @(posedge clk_i); #1;
      if (mem_cyc_o && mem_stb_o && !rst_i) begin
        m_adr = mem_adr_o; m_we = mem_we_o; m_dat = '0; m_abort = 1'b0; m_hold_ok = 1'b1;
        for (int w = 0; w < 3 && !m_abort; w++) begin
          @(posedge clk_i); #1;
          if (rst_i || !mem_cyc_o) m_abort = 1'b1;
        end
        for (int b = 0; b < 4 && !m_abort; b++) begin
          logic [1:0] bb;
          bb = b[1:0];
          beat_no   = b;
          mem_ack_i = 1'b1;
          mem_dat_i = mem_words[{m_adr[11:4], bb}];
          if (mem_adr_o !== m_adr || mem_we_o !== m_we || !mem_stb_o) m_hold_ok = 1'b0;
          if (m_we) m_dat[32*b +: 32] = mem_dat_o;
          @(posedge clk_i); #1;
          if (rst_i) m_abort = 1'b1;
        end
        mem_ack_i = 1'b0; beat_no = -1;
        if (!m_abort) begin
          if (m_we)
            for (int b = 0; b < 4; b++) mem_words[{m_adr[11:4], 2'(b)}] = m_dat[32*b +: 32];
          bursts_seen++;
          chk("mem_release", mem_cyc_o, 1'b0);
          chk("mem_hold", m_hold_ok, 1'b1);
          chk("burst_expected", exp_bursts.size() != 0, 1'b1);
          if (exp_bursts.size() != 0) begin
            m_exp = exp_bursts.pop_front();
            chk("burst_adr_we", {m_we, m_adr}, {m_exp.we, m_exp.adr});
            if (m_exp.we) chk("burst_wdata", m_dat, m_exp.dat);
          end
        end
      end
    end
  end

  // CPU ack monitor: every ack pops one expected dat_o.
  logic [31:0] rd_exp;
  initial forever begin
    @(posedge clk_i); #1;
    if (cpu_ack_o) begin
      acks_seen++;
      chk("ack_expected", exp_rd.size() != 0, 1'b1);
      if (exp_rd.size() != 0) begin
        rd_exp = exp_rd.pop_front();
        chk("cpu_dat", cpu_dat_o, rd_exp);
      end
    end
  end

  // One CPU access; exp_lat > 0 also checks the accept-to-ack distance.
  task automatic cpu_op(input string tag, input logic we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] wdat,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1; cpu_we_i = we;
    cpu_sel_i = sel; cpu_adr_i = adr; cpu_dat_i = wdat;
    for (int i = 0; i < 50 && cpu_stall_o; i++) begin @(posedge clk_i); #1; end
    @(posedge clk_i);
    exp_rd.push_back(exp);
    #1; cpu_stb_i = 1'b0;
    lat = 0;
    while (!cpu_ack_o && lat < 400) begin @(posedge clk_i); #1; lat++; end
    chk({tag, "_ack"}, cpu_ack_o, 1'b1);
    if (exp_lat > 0) chk({tag, "_lat"}, lat, exp_lat);
    cpu_cyc_i = 1'b0; cpu_we_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1, "watchdog");
  end

  int b0, a0, t;
  initial begin
    rst_i = 1'b1; cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0; cpu_we_i = 1'b0;
    cpu_sel_i = '0; cpu_adr_i = '0; cpu_dat_i = '0;
`ifdef SDRAM_CACHE_FLUSH_EN
    flush_i = 1'b0;
`endif
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_cpu", {cpu_ack_o, cpu_stall_o, cpu_dat_o}, '0);
    chk("rst_mem_ctl", {mem_cyc_o, mem_stb_o, mem_we_o, mem_sel_o}, '0);
    chk("rst_mem_adr_dat", {mem_adr_o, mem_dat_o}, '0);
`ifdef SDRAM_CACHE_FLUSH_EN
    chk("rst_flush_done", flush_done_o, 1'b0);
`endif
    #2 rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Cold read miss, then a hit in the same line.
    push_burst(1'b0, 32'h100, '0);
    cpu_op("cold_miss", 1'b0, 32'h104, 4'hf, 0, A1, 0);
    b0 = bursts_seen;
    cpu_op("hit_rd", 1'b0, 32'h108, 4'hf, 0, A2, 1);
    // Write hit with byte merge, then read it back.
    cpu_op("wr_hit", 1'b1, 32'h104, 4'b0011, 32'hDEAD_BEEF, 32'h0, 1);
    cpu_op("rd_merged", 1'b0, 32'h104, 4'hf, 0, 32'h1122_BEEF, 1);
    chk("hits_no_mem", bursts_seen, b0);

    // Dirty eviction: writeback of the old line, then fill of the new one.
    push_burst(1'b1, 32'h100, {A3, A2, 32'h1122_BEEF, A0});
    push_burst(1'b0, 32'h500, '0);
    cpu_op("evict", 1'b0, 32'h504, 4'hf, 0, 32'hC0DE_0504, 0);
    chk("evict_bursts_done", exp_bursts.size(), 0);
    // Clean eviction; the written-back data must come back.
    push_burst(1'b0, 32'h100, '0);
    cpu_op("refill", 1'b0, 32'h104, 4'hf, 0, 32'h1122_BEEF, 0);

    // Write miss: fill first, then merge.
    push_burst(1'b0, 32'h200, '0);
    cpu_op("wr_miss", 1'b1, 32'h208, 4'hf, 32'h55AA_55AA, 32'h0, 0);
    cpu_op("wr_miss_rd", 1'b0, 32'h208, 4'hf, 0, 32'h55AA_55AA, 1);
    cpu_op("wr_miss_nb", 1'b0, 32'h20C, 4'hf, 0, 32'hC0DE_020C, 1);

    // Reset during the second fill beat.
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1; cpu_we_i = 1'b0; cpu_adr_i = 32'h300; cpu_sel_i = 4'hf;
    @(posedge clk_i); #1; cpu_stb_i = 1'b0;
    t = 0;
    while (!(mem_ack_i && beat_no == 1) && t < 200) begin @(posedge clk_i); #2; t++; end
    chk("rst_reach_beat2", mem_ack_i && beat_no == 1, 1'b1);
    rst_i = 1'b1; cpu_cyc_i = 1'b0;
    #1;
    chk("rst_mid_cyc", {mem_cyc_o, mem_stb_o, cpu_stall_o}, '0);
    repeat (2) @(posedge clk_i);
    #3 rst_i = 1'b0;
    push_burst(1'b0, 32'h100, '0);
    cpu_op("post_rst_miss", 1'b0, 32'h108, 4'hf, 0, A2, 0);
    push_burst(1'b0, 32'h300, '0);
    cpu_op("post_rst_same", 1'b0, 32'h300, 4'hf, 0, 32'hC0DE_0300, 0);

    // CPU drops cyc during a fill.
    push_burst(1'b0, 32'h400, '0);
    a0 = acks_seen;
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1; cpu_we_i = 1'b0; cpu_adr_i = 32'h404; cpu_sel_i = 4'hf;
    @(posedge clk_i); #1; cpu_stb_i = 1'b0;
    t = 0;
    while (!mem_ack_i && t < 200) begin @(posedge clk_i); #1; t++; end
    cpu_cyc_i = 1'b0;
    t = 0;
    while (cpu_stall_o && t < 200) begin @(posedge clk_i); #1; t++; end
    chk("abort_idle", cpu_stall_o, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("abort_no_ack", acks_seen, a0);
    chk("abort_burst_done", exp_bursts.size(), 0);
    cpu_op("abort_line_valid", 1'b0, 32'h404, 4'hf, 0, 32'hC0DE_0404, 1);

`ifdef SDRAM_CACHE_FLUSH_EN
    // Dirty lines at index 3 and 60, then flush.
    push_burst(1'b0, 32'h030, '0);
    cpu_op("fl_wr3", 1'b1, 32'h034, 4'hf, 32'h3333_0003, 32'h0, 0);
    push_burst(1'b0, 32'h3C0, '0);
    cpu_op("fl_wr60", 1'b1, 32'h3C8, 4'b1000, 32'h6060_0060, 32'h0, 0);
    push_burst(1'b1, 32'h030, {32'hC0DE_003C, 32'hC0DE_0038, 32'h3333_0003, 32'hC0DE_0030});
    push_burst(1'b1, 32'h3C0, {32'hC0DE_03CC, 32'h60DE_03C8, 32'hC0DE_03C4, 32'hC0DE_03C0});
    b0 = bursts_seen;
    flush_i = 1'b1;
    @(posedge clk_i); #1; flush_i = 1'b0;
    t = 0;
    while (!flush_done_o && t < 3000) begin @(posedge clk_i); #1; t++; end
    chk("flush_done", flush_done_o, 1'b1);
    chk("flush_bursts", bursts_seen - b0, 2);
    @(posedge clk_i); #1;
    chk("flush_done_pulse", flush_done_o, 1'b0);
    cpu_op("fl_rd3", 1'b0, 32'h034, 4'hf, 0, 32'h3333_0003, 1);
    cpu_op("fl_rd60", 1'b0, 32'h3C8, 4'hf, 0, 32'h60DE_03C8, 1);
`endif

    repeat (4) @(posedge clk_i);
    #1;
    chk("bursts_pending", exp_bursts.size(), 0);
    chk("acks_pending", exp_rd.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sdram32_line_cache.md
# sdram32_line_cache

Direct-mapped, write-back line cache between the CPU-side Wishbone bus and `sdram32_controller`. Every controller transaction is a fixed 4-beat sequential burst with one byte mask for all beats. This block therefore converts single-word CPU accesses into whole-line fills and whole-line writebacks of 4×32-bit words. Hits complete without touching SDRAM.

## Interface
- `LINES`, 64: number of cache lines; a power of 2, from 4 to 256.
- `clk_i`  in  1: clock; all logic is on the rising edge.
- `rst_i`  in  1: reset, asynchronous, active-high.
- `cpu`  `if_wb.slave`  -: CPU side, byte addresses, 32-bit data. Uses `cyc`, `stb`, `we`, `sel[3:0]`, `adr[31:0]`, `dat_i`, `dat_o`, `ack`, `stall`.
- `mem`  `if_wb.master`  -: controller side, same signal set. Only `adr[26:4]` is meaningful; `adr[3:0]` is always 0.
- `flush_i`  in  1: present only with `SDRAM_CACHE_FLUSH_EN`. Requests a writeback of all dirty lines.
- `flush_done_o`  out  1: present only with `SDRAM_CACHE_FLUSH_EN`. One-cycle pulse when the flush completes.

## Operation
- **Address split:**
  - offset = `adr[3:2]`
  - index = `adr[3+log2(LINES):4]`
  - tag = `adr[26:4+log2(LINES)]`
  - `adr[31:27]` is ignored.
- **Per-line storage:** valid bit, dirty bit, tag, and 4 data words. Valid and dirty are flops cleared by reset; tag and data are not reset.
- **Request acceptance:** a request is accepted when `cpu.cyc & cpu.stb & ~cpu.stall`. The block latches adr, we, sel and dat_i.
- **States:**
  - S_IDLE: `stall`=0. An accepted request goes to S_LOOKUP.
  - S_LOOKUP:
    - Hit (valid and tag equal): a read returns the word; a write merges bytes per `sel` and sets dirty. `cpu.ack` pulses and the block returns to S_IDLE.
    - Miss with the victim dirty: go to S_WB.
    - Miss with the victim clean: go to S_FILL.
  - S_WB: `mem.we`=1, `sel`=4'hf, `adr` = {victim tag, index, 4'b0}. `mem.dat_o` = victim word[beat]. After the 4th ack, clear dirty and go to S_FILL.
  - S_FILL: `mem.we`=0, `adr` = {request tag, index, 4'b0}. `mem.dat_i` is captured into word[beat] on each ack. After the 4th ack, write tag, set valid, clear dirty, and go to S_LOOKUP; it now hits.
  - S_FLUSH: present only with the macro; described under Configuration.
- **Beat counter:** 2 bits. It is cleared on entering S_WB or S_FILL and increments on each `mem.ack`. It wraps 3→0 on the 4th ack, which ends the burst.
- **mem bus hold:** `mem.cyc`/`mem.stb`/`mem.adr`/`mem.we`/`mem.sel` stay constant from burst start through the 4th ack. The controller samples `we`/`adr` several cycles after `stb` rises.
- **mem bus release:** `mem.cyc`/`mem.stb` drop in the cycle after the 4th ack, for at least one cycle between bursts.
- **Write miss:** the line is filled first, then merged in S_LOOKUP. The block never issues a partial-line write.
- **CPU drops `cyc` mid-miss:** the line operation still completes, for cache consistency. `cpu.ack` is suppressed if `cpu.cyc`=0 in the completion cycle.
- **Reset mid-burst:** `mem.cyc` drops immediately, all lines are invalidated, and dirty data is lost. This is by design.

## Timing
- **Reset values:**
  - `cpu.ack`=0, `cpu.stall`=0, `cpu.dat_o`=0
  - `mem.cyc`=0, `mem.stb`=0, `mem.we`=0, `mem.sel`=0, `mem.adr`=0, `mem.dat_o`=0
  - `flush_done_o`=0
- **Hit:** accepted at edge N, `cpu.ack` high for cycle N+1 with `dat_o` valid. Throughput is one access per 2 cycles.
- **CPU stall:** `cpu.stall`=1 in every state except S_IDLE.
- **Clean miss:** ack = fill latency (controller-bound: activate, CAS 2, 4 beats) + 2 cycles.
- **Dirty miss:** writeback, then fill, then 2 cycles.
- **`cpu.dat_o`:** holds the last read value; it is 0 after a write ack.

## Configuration
- **Macro `SDRAM_CACHE_FLUSH_EN`:** when defined, the `flush_i`/`flush_done_o` ports and the S_FLUSH state exist.
- **Flush entry:** `flush_i` sampled high in S_IDLE, with no CPU request accepted that cycle, enters S_FLUSH. A CPU request in the same cycle has priority; the flush is taken on a later idle cycle only if `flush_i` is still high.
- **Flush scan:** S_FLUSH scans index 0..LINES-1 and writes back each dirty line as in S_WB. Lines stay valid.
- **Flush completion:** after the last index, `flush_done_o` pulses for 1 cycle and the block returns to S_IDLE.
- **Without the macro:** neither port exists and `flush_i` behaviour is absent.

## Test plan
- **Cold read miss:** after reset, read 0x0000_0104 with a memory model holding line 0x100 = {A0,A1,A2,A3} -> one read burst at `mem.adr`=0x100, `cpu.dat_o`=A1, then a read of 0x108 hits with ack 1 cycle after accept, `dat_o`=A2.
- **Write hit byte merge:** write 0xDEADBEEF `sel`=4'b0011 to 0x104 (cached A1=0x11223344) -> no mem traffic, read 0x104 = 0x1122BEEF, line dirty.
- **Dirty eviction:** LINES=64, dirty line at 0x104, then read 0x0000_0504 (same index, new tag) -> write burst at 0x100 with data {A0, 0x1122BEEF, A2, A3} in order, then read burst at 0x500, then ack.
- **Reset mid-fill:** assert `rst_i` during the 2nd fill beat -> `mem.cyc`=0 the same cycle, next access to the same address misses.
- **CPU abort:** `cpu.cyc` dropped during a fill -> burst completes, no `cpu.ack`, line valid afterwards.
- **Flush (with `SDRAM_CACHE_FLUSH_EN`):** dirty lines at indices 3 and 60 -> exactly two write bursts (index 3 first), then `flush_done_o` 1-cycle pulse, then reads of both lines hit.
